// File: rtl/lot_pkg.sv
// Shared types and sizing for the lot occupancy counter and HEX display.
package lot_pkg;
   localparam int LOT_CAPACITY = 16;
   localparam int LOT_CW       = 5;

   typedef enum logic [2:0] {
      IDLE,
      EN_A,
      EN_AB,
      EN_B,
      EX_B,
      EX_AB,
      EX_A,
      WAIT_CLR
   } gate_state_t;
endpackage

// File: rtl/gate_direction_fsm.sv
// Decodes car direction from the synchronized gate sensor pair.
module gate_direction_fsm
   import lot_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic a_s,
   input  logic b_s,
   output logic entry_evt,
   output logic exit_evt
);
   gate_state_t state_q, state_d;
   logic [1:0]  ab;

   assign ab = {a_s, b_s};

   // Events fire on the edge that returns to IDLE so the count moves with it.
   always_comb begin
      state_d   = state_q;
      entry_evt = 1'b0;
      exit_evt  = 1'b0;
      unique case (state_q)
         IDLE: begin
            case (ab)
               2'b10:   state_d = EN_A;
               2'b01:   state_d = EX_B;
               2'b11:   state_d = WAIT_CLR;
               default: state_d = IDLE;
            endcase
         end
         EN_A: begin
            case (ab)
               2'b11:   state_d = EN_AB;
               2'b00:   state_d = IDLE;
               2'b01:   state_d = WAIT_CLR;
               default: state_d = EN_A;
            endcase
         end
         EN_AB: begin
            case (ab)
               2'b01:   state_d = EN_B;
               2'b10:   state_d = EN_A;
               2'b00:   state_d = WAIT_CLR;
               default: state_d = EN_AB;
            endcase
         end
         EN_B: begin
            case (ab)
               2'b00: begin
                  state_d   = IDLE;
                  entry_evt = 1'b1;
               end
               2'b11:   state_d = EN_AB;
               2'b10:   state_d = WAIT_CLR;
               default: state_d = EN_B;
            endcase
         end
         EX_B: begin
            case (ab)
               2'b11:   state_d = EX_AB;
               2'b00:   state_d = IDLE;
               2'b10:   state_d = WAIT_CLR;
               default: state_d = EX_B;
            endcase
         end
         EX_AB: begin
            case (ab)
               2'b10:   state_d = EX_A;
               2'b01:   state_d = EX_B;
               2'b00:   state_d = WAIT_CLR;
               default: state_d = EX_AB;
            endcase
         end
         EX_A: begin
            case (ab)
               2'b00: begin
                  state_d  = IDLE;
                  exit_evt = 1'b1;
               end
               2'b11:   state_d = EX_AB;
               2'b01:   state_d = WAIT_CLR;
               default: state_d = EX_A;
            endcase
         end
         WAIT_CLR: begin
            if (ab == 2'b00) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end
endmodule

// File: rtl/lot_occupancy_counter.sv
// Synchronizes gate sensors and keeps a saturating count of cars in the lot.
module lot_occupancy_counter
   import lot_pkg::*;
#(
   parameter int CAPACITY    = LOT_CAPACITY,
   parameter int CW          = LOT_CW,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          a,
   input  logic          b,
   output logic [CW-1:0] count,
   output logic          car_in,
   output logic          car_out,
   output logic          full,
   output logic          empty
);
   localparam logic [CW-1:0] CAP_W = CW'(CAPACITY);

   logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
   logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   car_in_q, car_in_d;
   logic                   car_out_q, car_out_d;
   logic                   entry_evt, exit_evt;

   gate_direction_fsm u_fsm (
      .clk       (clk),
      .reset     (reset),
      .a_s       (a_sync_q[SYNC_STAGES-1]),
      .b_s       (b_sync_q[SYNC_STAGES-1]),
      .entry_evt (entry_evt),
      .exit_evt  (exit_evt)
   );

   // Pulses still fire at the limits; only the count saturates.
   always_comb begin
      a_sync_d  = {a_sync_q[SYNC_STAGES-2:0], a};
      b_sync_d  = {b_sync_q[SYNC_STAGES-2:0], b};
      count_d   = count_q;
      car_in_d  = entry_evt;
      car_out_d = exit_evt;
      if (entry_evt && count_q != CAP_W)
         count_d = count_q + CW'(1);
      else if (exit_evt && count_q != '0)
         count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_sync_q  <= '0;
         b_sync_q  <= '0;
         count_q   <= '0;
         car_in_q  <= 1'b0;
         car_out_q <= 1'b0;
      end else begin
         a_sync_q  <= a_sync_d;
         b_sync_q  <= b_sync_d;
         count_q   <= count_d;
         car_in_q  <= car_in_d;
         car_out_q <= car_out_d;
      end
   end

   assign count   = count_q;
   assign car_in  = car_in_q;
   assign car_out = car_out_q;
   assign full    = (count_q == CAP_W);
   assign empty   = (count_q == '0);
endmodule
